// File: rtl/dm_responder.sv
// Data-memory responder for the M-stage data port: byte-lane RAM with a clear-after-reset
// sweep, combinational reads, and a first-word-fall-through trace FIFO of accepted stores.

package dm_responder_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  byteen;
    } trace_rec_t;
endpackage

module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 3072,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned TRACE_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    input  logic [31:0] m_inst_addr,
    output logic [31:0] m_data_rdata,
    output logic        dm_busy,
    output logic        dm_fault,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data,
    output logic [3:0]  trace_byteen,
    output logic        trace_overflow
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned PTR_W = $clog2(TRACE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;
    logic               clearing;
    logic               busy_q;
    logic               fault_q;

    logic [31:0]        mem [DEPTH_WORDS];
    trace_rec_t         fifo [TRACE_DEPTH];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_CLEAR;
            clr_idx_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            busy_q    <= (state_d == S_CLEAR);
        end
    end

    // Clear sweep visits every word once, then hands over to RUN
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        clearing  = 1'b0;
        case (state_q)
            S_CLEAR: begin
                clearing  = 1'b1;
                clr_idx_d = clr_idx_q + IDX_W'(1);
                if (clr_idx_q == IDX_W'(DEPTH_WORDS - 1)) begin
                    state_d   = S_RUN;
                    clr_idx_d = '0;
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Address decode and store legality
    logic [31:0]      offset;
    logic [29:0]      word_off;
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             running;
    logic             lanes_ok;
    logic             store_ok;
    logic             store_bad;
    logic [31:0]      lane_mask;
    trace_rec_t       rec_new;
    logic             unused_lo;

    assign offset    = m_data_addr - BASE_ADDR;
    assign word_off  = offset[31:2];
    assign unused_lo = ^offset[1:0];
    assign in_range  = (m_data_addr >= BASE_ADDR) && (word_off < 30'(DEPTH_WORDS));
    assign idx       = word_off[IDX_W-1:0];
    assign running   = (state_q == S_RUN);
    assign lane_mask = {{8{m_data_byteen[3]}}, {8{m_data_byteen[2]}},
                        {8{m_data_byteen[1]}}, {8{m_data_byteen[0]}}};

    always_comb begin
        lanes_ok = 1'b0;
        case (m_data_byteen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: lanes_ok = 1'b1;
            default:                   lanes_ok = 1'b0;
        endcase
    end

    assign store_ok  = running && (m_data_byteen != 4'b0000) && lanes_ok && in_range;
    assign store_bad = running && (m_data_byteen != 4'b0000) && !(lanes_ok && in_range);

    assign rec_new.pc     = m_inst_addr;
    assign rec_new.addr   = BASE_ADDR + 32'({idx, 2'b00});
    assign rec_new.data   = m_data_wdata & lane_mask;
    assign rec_new.byteen = m_data_byteen;

    // Old word is visible during the store cycle; the write lands at the edge
    assign m_data_rdata = (running && in_range) ? mem[idx] : 32'h0;

    always_ff @(posedge clk) begin
        if (clearing) begin
            mem[clr_idx_q] <= '0;
        end else if (store_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (m_data_byteen[i]) mem[idx][8*i +: 8] <= m_data_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) fault_q <= 1'b0;
        else        fault_q <= store_bad;
    end

    // Trace FIFO; the head is kept in a register so fields hold once drained
    logic [PTR_W-1:0] wr_q, rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q;
    logic             ovf_q;
    trace_rec_t       head_q, head_d;
    logic             full, push, pop, drop;

    always_comb begin
        full    = (count_q == CNT_W'(TRACE_DEPTH));
        pop     = valid_q && trace_ready;
        push    = store_ok && (!full || pop);
        drop    = store_ok && full && !pop;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        rd_d    = rd_q + PTR_W'(pop);
        head_d  = head_q;
        if (count_d != '0) begin
            if (push && (wr_q == rd_d)) head_d = rec_new;
            else                        head_d = fifo[rd_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_q] <= rec_new;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            head_q  <= '0;
        end else begin
            wr_q    <= wr_q + PTR_W'(push);
            rd_q    <= rd_d;
            count_q <= count_d;
            valid_q <= (count_d != '0);
            ovf_q   <= ovf_q | drop;
            head_q  <= head_d;
        end
    end

    assign dm_busy        = busy_q;
    assign dm_fault       = fault_q;
    assign trace_valid    = valid_q;
    assign trace_overflow = ovf_q;
    assign trace_pc       = head_q.pc;
    assign trace_addr     = head_q.addr;
    assign trace_data     = head_q.data;
    assign trace_byteen   = head_q.byteen;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: vector table for single stores plus hand sequences
// for clear timing, trace FIFO overflow/drain, full push+pop and mid-run reset.

module tb_dm_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_inst_addr;
    logic [31:0] m_data_rdata;
    logic        dm_busy;
    logic        dm_fault;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;
    logic [3:0]  trace_byteen;
    logic        trace_overflow;

    int total = 0;
    int bad   = 0;

    dm_responder dut (
        .clk           (clk),
        .reset         (reset),
        .m_data_addr   (m_data_addr),
        .m_data_wdata  (m_data_wdata),
        .m_data_byteen (m_data_byteen),
        .m_inst_addr   (m_inst_addr),
        .m_data_rdata  (m_data_rdata),
        .dm_busy       (dm_busy),
        .dm_fault      (dm_fault),
        .trace_valid   (trace_valid),
        .trace_ready   (trace_ready),
        .trace_pc      (trace_pc),
        .trace_addr    (trace_addr),
        .trace_data    (trace_data),
        .trace_byteen  (trace_byteen),
        .trace_overflow(trace_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] pc;
        logic [31:0] pre;      // rdata at addr before the edge
        logic [31:0] rd_addr;  // address read back after the edge
        logic [31:0] post;
        logic        fault;
        logic        push;
        logic [31:0] t_addr;
        logic [31:0] t_data;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                         input logic [31:0] pc);
        m_data_addr   = a;
        m_data_wdata  = d;
        m_data_byteen = be;
        m_inst_addr   = pc;
        tick();
        m_data_byteen = 4'b0000;
    endtask

    task automatic wait_clear(input string nm);
        int n;
        n = 0;
        while (dm_busy && n < 5000) begin
            tick();
            n++;
        end
        chk(nm, 32'(n), 32'd3072);
    endtask

    initial begin
        vecs[0] = '{32'h20, 32'h1234_5678, 4'b1111, 32'h3004, 32'h0,         32'h20,   32'h1234_5678, 1'b0, 1'b1, 32'h20,   32'h1234_5678};
        vecs[1] = '{32'h22, 32'hABAB_ABAB, 4'b0100, 32'h3008, 32'h1234_5678, 32'h20,   32'h12AB_5678, 1'b0, 1'b1, 32'h20,   32'h00AB_0000};
        vecs[2] = '{32'h20, 32'hFFFF_FFFF, 4'b0101, 32'h300C, 32'h12AB_5678, 32'h20,   32'h12AB_5678, 1'b1, 1'b0, 32'h0,    32'h0};
        vecs[3] = '{32'h3000, 32'hFFFF_FFFF, 4'b1111, 32'h3010, 32'h0,       32'h3000, 32'h0,         1'b1, 1'b0, 32'h0,    32'h0};
        vecs[4] = '{32'h21, 32'h9999_CDEF, 4'b0011, 32'h3014, 32'h12AB_5678, 32'h20,   32'h12AB_CDEF, 1'b0, 1'b1, 32'h20,   32'h0000_CDEF};
        vecs[5] = '{32'h24, 32'hFFFF_FFFF, 4'b0000, 32'h3018, 32'h0,         32'h24,   32'h0,         1'b0, 1'b0, 32'h0,    32'h0};
        vecs[6] = '{32'h2FFC, 32'hAA11_2233, 4'b1000, 32'h301C, 32'h0,       32'h2FFC, 32'hAA00_0000, 1'b0, 1'b1, 32'h2FFC, 32'hAA00_0000};
        vecs[7] = '{32'h27, 32'h5566_7788, 4'b1100, 32'h3020, 32'h0,         32'h24,   32'h5566_0000, 1'b0, 1'b1, 32'h24,   32'h5566_0000};
        vecs[8] = '{32'h24, 32'h0102_0304, 4'b0110, 32'h3024, 32'h5566_0000, 32'h24,   32'h5566_0000, 1'b1, 1'b0, 32'h0,    32'h0};

        reset         = 1'b0;
        m_data_addr   = 32'h0;
        m_data_wdata  = 32'h0;
        m_data_byteen = 4'b0000;
        m_inst_addr   = 32'h0;
        trace_ready   = 1'b0;
        repeat (3) tick();

        // reset state
        chk1("rst_busy", dm_busy, 1'b1);
        chk1("rst_valid", trace_valid, 1'b0);
        chk1("rst_ovf", trace_overflow, 1'b0);
        chk1("rst_fault", dm_fault, 1'b0);
        chk("rst_rdata", m_data_rdata, 32'h0);
        chk("rst_tpc", trace_pc, 32'h0);
        chk("rst_tdata", trace_data, 32'h0);

        // clear sweep with a store held on that must be ignored
        m_data_addr   = 32'h10;
        m_data_wdata  = 32'hFFFF_FFFF;
        m_data_byteen = 4'b1111;
        m_inst_addr   = 32'h2000;
        @(negedge clk);
        reset = 1'b1;
        wait_clear("clear_cycles");
        m_data_byteen = 4'b0000;
        #1;
        chk("clear_rd10", m_data_rdata, 32'h0);
        chk1("clear_valid", trace_valid, 1'b0);
        chk1("clear_fault", dm_fault, 1'b0);

        // table of single stores, consumer always ready
        trace_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            m_data_addr   = vecs[i].addr;
            m_data_wdata  = vecs[i].wdata;
            m_data_byteen = vecs[i].be;
            m_inst_addr   = vecs[i].pc;
            #1;
            chk($sformatf("v%0d_pre", i), m_data_rdata, vecs[i].pre);
            tick();
            m_data_byteen = 4'b0000;
            m_data_addr   = vecs[i].rd_addr;
            #1;
            chk($sformatf("v%0d_post", i), m_data_rdata, vecs[i].post);
            chk1($sformatf("v%0d_fault", i), dm_fault, vecs[i].fault);
            chk1($sformatf("v%0d_valid", i), trace_valid, vecs[i].push);
            if (vecs[i].push) begin
                chk($sformatf("v%0d_tpc", i), trace_pc, vecs[i].pc);
                chk($sformatf("v%0d_taddr", i), trace_addr, vecs[i].t_addr);
                chk($sformatf("v%0d_tdata", i), trace_data, vecs[i].t_data);
                chk($sformatf("v%0d_tbe", i), 32'(trace_byteen), 32'(vecs[i].be));
            end
        end

        // overflow: nine stores into an 8-deep FIFO with consumer stalled
        trace_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            store(32'h40 + 32'(4 * k), 32'(k) + 32'd1, 4'b1111, 32'h3000 + 32'(4 * k));
            chk1($sformatf("ovf_k%0d", k), trace_overflow, (k == 8));
        end
        chk1("ovf_valid", trace_valid, 1'b1);
        m_data_addr = 32'h60;
        #1;
        chk("ovf_memwrite", m_data_rdata, 32'd9);
        trace_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk1($sformatf("drain%0d_valid", k), trace_valid, 1'b1);
            chk($sformatf("drain%0d_pc", k), trace_pc, 32'h3000 + 32'(4 * k));
            chk($sformatf("drain%0d_addr", k), trace_addr, 32'h40 + 32'(4 * k));
            chk($sformatf("drain%0d_data", k), trace_data, 32'(k) + 32'd1);
            tick();
        end
        chk1("drain_empty", trace_valid, 1'b0);
        chk1("drain_ovf_sticky", trace_overflow, 1'b1);
        chk("drain_hold_pc", trace_pc, 32'h301C);

        // asynchronous reset in the middle of a cycle during RUN
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk1("mid_rst_busy", dm_busy, 1'b1);
        chk1("mid_rst_valid", trace_valid, 1'b0);
        chk1("mid_rst_ovf", trace_overflow, 1'b0);
        chk("mid_rst_rdata", m_data_rdata, 32'h0);
        chk("mid_rst_tpc", trace_pc, 32'h0);
        repeat (2) tick();
        @(negedge clk);
        reset = 1'b1;
        wait_clear("reclear_cycles");
        m_data_addr = 32'h20;
        #1;
        chk("reclear_rd20", m_data_rdata, 32'h0);
        m_data_addr = 32'h60;
        #1;
        chk("reclear_rd60", m_data_rdata, 32'h0);
        m_data_addr = 32'h2FFC;
        #1;
        chk("reclear_rd2ffc", m_data_rdata, 32'h0);

        // full FIFO with push and pop in the same cycle
        trace_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            store(32'h80 + 32'(4 * k), 32'hC0 + 32'(k), 4'b1111, 32'h4000 + 32'(4 * k));
        end
        chk1("full_ovf", trace_overflow, 1'b0);
        chk("full_head", trace_pc, 32'h4000);
        trace_ready = 1'b1;
        store(32'hA0, 32'hC8, 4'b1111, 32'h4020);
        trace_ready = 1'b0;
        #1;
        chk1("pp_ovf", trace_overflow, 1'b0);
        chk("pp_head", trace_pc, 32'h4004);
        begin
            int n;
            n = 0;
            trace_ready = 1'b1;
            while (trace_valid && n < 20) begin
                chk($sformatf("pp_drain%0d_pc", n), trace_pc, 32'h4004 + 32'(4 * n));
                tick();
                n++;
            end
            chk("pp_count", 32'(n), 32'd8);
        end
        chk1("pp_ovf_end", trace_overflow, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
